// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI4-Lite types, response codes and strobe helper
package axi_lite_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  strb_t;
    typedef logic [1:0]  resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    function automatic data_t apply_strb(input data_t old_val, input data_t new_val, input strb_t strb);
        data_t res;
        res = old_val;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = new_val[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_lite_slave_regs_if.sv
// rtl/axi_lite_slave_regs_if.sv - AXI4-Lite bus bundle with master/slave modports
interface axi_lite_slave_regs_if;
    import axi_lite_pkg::*;

    addr_t       awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    data_t       wdata;
    strb_t       wstrb;
    logic        wvalid;
    logic        wready;
    resp_t       bresp;
    logic        bvalid;
    logic        bready;
    addr_t       araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    data_t       rdata;
    resp_t       rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi_lite_addr_decode.sv
// rtl/axi_lite_addr_decode.sv - byte address to register index, range hit and alignment check
module axi_lite_addr_decode
    import axi_lite_pkg::*;
#(
    parameter int    NUM_REGS  = 16,
    parameter addr_t BASE_ADDR = 32'h0000_0000
) (
    input  addr_t       i_addr,
    output logic [7:0]  o_index,
    output logic        o_hit,
    output logic        o_misaligned
);

    addr_t w_offset;

    // BASE_ADDR is window-aligned, so offset[1:0] equals addr[1:0]
    assign w_offset     = i_addr - BASE_ADDR;
    assign o_misaligned = (w_offset[1:0] != 2'b00);
    assign o_index      = w_offset[9:2];
    assign o_hit        = !o_misaligned && ({2'b00, w_offset[31:2]} < 32'(NUM_REGS));

endmodule

// File: rtl/axi_lite_slave_regs.sv
// rtl/axi_lite_slave_regs.sv - AXI4-Lite register bank; AXI_LITE_SLAVE_REGS_DECERR_EN selects DECERR for out-of-range
module axi_lite_slave_regs
    import axi_lite_pkg::*;
#(
    parameter int    NUM_REGS  = 16,
    parameter addr_t BASE_ADDR = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rstn,
    axi_lite_slave_regs_if.slave     bus,
    output logic [NUM_REGS*32-1:0]   regs_o,
    output logic [NUM_REGS-1:0]      wr_pulse_o
);

    localparam logic [0:0] WR_IDLE = 1'b0;
    localparam logic [0:0] WR_RESP = 1'b1;
    localparam logic [0:0] RD_IDLE = 1'b0;
    localparam logic [0:0] RD_DATA = 1'b1;

`ifdef AXI_LITE_SLAVE_REGS_DECERR_EN
    localparam resp_t RANGE_RESP = RESP_DECERR;
`else
    localparam resp_t RANGE_RESP = RESP_OKAY;
`endif

    logic [0:0]          r_wr_state;
    logic [0:0]          r_rd_state;
    logic                r_aw_held;
    logic                r_w_held;
    addr_t               r_awaddr;
    data_t               r_wdata;
    strb_t               r_wstrb;
    data_t               r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_wr_pulse;
    resp_t               r_bresp;
    resp_t               r_rresp;
    data_t               r_rdata;

    logic       w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    addr_t      w_wr_addr;
    data_t      w_wr_data;
    strb_t      w_wr_strb;
    logic [7:0] w_wr_idx, w_rd_idx;
    logic       w_wr_hit, w_wr_mis, w_rd_hit, w_rd_mis;
    data_t      w_rd_val;
    resp_t      w_wr_resp, w_rd_resp;
    logic       w_unused_prot;

    assign w_unused_prot = ^{bus.awprot, bus.arprot};

    // Readies derive from state flops only, never from valid inputs
    assign bus.awready = (r_wr_state == WR_IDLE) && !r_aw_held;
    assign bus.wready  = (r_wr_state == WR_IDLE) && !r_w_held;
    assign bus.bvalid  = (r_wr_state == WR_RESP);
    assign bus.bresp   = r_bresp;
    assign bus.arready = (r_rd_state == RD_IDLE);
    assign bus.rvalid  = (r_rd_state == RD_DATA);
    assign bus.rdata   = r_rdata;
    assign bus.rresp   = r_rresp;

    assign w_aw_hs   = bus.awvalid && bus.awready;
    assign w_w_hs    = bus.wvalid && bus.wready;
    assign w_ar_hs   = bus.arvalid && bus.arready;
    assign w_wr_addr = r_aw_held ? r_awaddr : bus.awaddr;
    assign w_wr_data = r_w_held ? r_wdata : bus.wdata;
    assign w_wr_strb = r_w_held ? r_wstrb : bus.wstrb;
    assign w_commit  = (r_wr_state == WR_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

    axi_lite_addr_decode #(.NUM_REGS(NUM_REGS), .BASE_ADDR(BASE_ADDR)) u_aw_dec (
        .i_addr(w_wr_addr), .o_index(w_wr_idx), .o_hit(w_wr_hit), .o_misaligned(w_wr_mis)
    );

    axi_lite_addr_decode #(.NUM_REGS(NUM_REGS), .BASE_ADDR(BASE_ADDR)) u_ar_dec (
        .i_addr(bus.araddr), .o_index(w_rd_idx), .o_hit(w_rd_hit), .o_misaligned(w_rd_mis)
    );

    assign w_wr_resp = w_wr_mis ? RESP_SLVERR : (w_wr_hit ? RESP_OKAY : RANGE_RESP);
    assign w_rd_resp = w_rd_mis ? RESP_SLVERR : (w_rd_hit ? RESP_OKAY : RANGE_RESP);

    always_comb begin
        w_rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_rd_hit && (w_rd_idx == 8'(i))) begin
                w_rd_val = r_regs[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_state <= WR_IDLE;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bresp    <= RESP_OKAY;
            r_wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_wr_pulse <= '0;
            case (r_wr_state)
                WR_IDLE: begin
                    if (w_commit) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (w_wr_hit && (w_wr_idx == 8'(i))) begin
                                r_regs[i]     <= apply_strb(r_regs[i], w_wr_data, w_wr_strb);
                                r_wr_pulse[i] <= 1'b1;
                            end
                        end
                        r_bresp    <= w_wr_resp;
                        r_aw_held  <= 1'b0;
                        r_w_held   <= 1'b0;
                        r_wr_state <= WR_RESP;
                    end else begin
                        if (w_aw_hs) begin
                            r_aw_held <= 1'b1;
                            r_awaddr  <= bus.awaddr;
                        end
                        if (w_w_hs) begin
                            r_w_held <= 1'b1;
                            r_wdata  <= bus.wdata;
                            r_wstrb  <= bus.wstrb;
                        end
                    end
                end
                WR_RESP: begin
                    if (bus.bready) begin
                        r_wr_state <= WR_IDLE;
                    end
                end
                default: r_wr_state <= WR_IDLE;
            endcase
        end
    end

    // Read samples r_regs before any same-edge commit lands, returning the old value
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rd_state <= RD_IDLE;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
        end else begin
            case (r_rd_state)
                RD_IDLE: begin
                    if (w_ar_hs) begin
                        r_rdata    <= w_rd_val;
                        r_rresp    <= w_rd_resp;
                        r_rd_state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (bus.rready) begin
                        r_rd_state <= RD_IDLE;
                    end
                end
                default: r_rd_state <= RD_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
        assign regs_o[32*g +: 32] = r_regs[g];
    end

    assign wr_pulse_o = r_wr_pulse;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// tb/tb_axi_lite_slave_regs.sv - directed self-checking bench for axi_lite_slave_regs
module tb_axi_lite_slave_regs;
    import axi_lite_pkg::*;

`ifdef AXI_LITE_SLAVE_REGS_DECERR_EN
    localparam resp_t EXP_RANGE = RESP_DECERR;
`else
    localparam resp_t EXP_RANGE = RESP_OKAY;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [511:0]  regs;
    logic [15:0]   pulse;
    int            n_vec = 0;
    int            n_err = 0;

    axi_lite_slave_regs_if bus ();

    axi_lite_slave_regs #(.NUM_REGS(16), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .rstn(rstn), .bus(bus), .regs_o(regs), .wr_pulse_o(pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %h required %h", tag, obs, want);
        end
    endtask

    task automatic wr(input addr_t a, input data_t d, input strb_t s, input resp_t er, input logic [15:0] ep);
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("wr_bvalid", 64'(bus.bvalid), 64'd1);
        chk("wr_bresp", 64'(bus.bresp), 64'(er));
        chk("wr_pulse", 64'(pulse), 64'(ep));
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        chk("wr_bvalid_drop", 64'(bus.bvalid), 64'd0);
        chk("wr_pulse_drop", 64'(pulse), 64'd0);
    endtask

    task automatic rd(input addr_t a, input data_t ed, input resp_t er);
        bus.araddr = a; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        chk("rd_rvalid", 64'(bus.rvalid), 64'd1);
        chk("rd_rdata", 64'(bus.rdata), 64'(ed));
        chk("rd_rresp", 64'(bus.rresp), 64'(er));
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        chk("rd_rvalid_drop", 64'(bus.rvalid), 64'd0);
    endtask

    initial begin
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

        tick(); tick();
        rstn = 1'b1;
        chk("rst_bvalid", 64'(bus.bvalid), 64'd0);
        chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
        chk("rst_awready", 64'(bus.awready), 64'd1);
        chk("rst_wready", 64'(bus.wready), 64'd1);
        chk("rst_arready", 64'(bus.arready), 64'd1);
        chk("rst_rdata", 64'(bus.rdata), 64'd0);
        chk("rst_regs_lo", regs[63:0], 64'd0);
        chk("rst_pulse", 64'(pulse), 64'd0);

        wr(32'h10, 32'hDEADBEEF, 4'hF, RESP_OKAY, 16'h0010);
        chk("reg4", 64'(regs[4*32 +: 32]), 64'hDEADBEEF);
        rd(32'h10, 32'hDEADBEEF, RESP_OKAY);

        wr(32'h08, 32'h11223344, 4'hF, RESP_OKAY, 16'h0004);
        wr(32'h08, 32'hAABBCCDD, 4'b0101, RESP_OKAY, 16'h0004);
        chk("reg2_strb", 64'(regs[2*32 +: 32]), 64'h11BB33DD);

        wr(32'h0C, 32'h12345678, 4'h0, RESP_OKAY, 16'h0008);
        chk("reg3_nostrb", 64'(regs[3*32 +: 32]), 64'd0);

        // W leads AW by three cycles, then B is back-pressured
        bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        chk("wfirst_wready", 64'(bus.wready), 64'd0);
        chk("wfirst_awready", 64'(bus.awready), 64'd1);
        tick(); tick();
        chk("wfirst_nocommit", 64'(bus.bvalid), 64'd0);
        bus.awaddr = 32'h20; bus.awvalid = 1'b1;
        tick();
        bus.awaddr = 32'h24;
        chk("wfirst_bvalid", 64'(bus.bvalid), 64'd1);
        chk("wfirst_pulse", 64'(pulse), 64'h0100);
        chk("reg8", 64'(regs[8*32 +: 32]), 64'hCAFEF00D);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bhold_bvalid", 64'(bus.bvalid), 64'd1);
            chk("bhold_bresp", 64'(bus.bresp), 64'(RESP_OKAY));
            chk("bhold_awready", 64'(bus.awready), 64'd0);
            chk("bhold_pulse", 64'(pulse), 64'd0);
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        chk("bdone_bvalid", 64'(bus.bvalid), 64'd0);
        chk("bdone_awready", 64'(bus.awready), 64'd1);
        chk("reg9_untouched", 64'(regs[9*32 +: 32]), 64'd0);
        tick();
        bus.awvalid = 1'b0;
        chk("awheld_awready", 64'(bus.awready), 64'd0);
        chk("awheld_bvalid", 64'(bus.bvalid), 64'd0);
        bus.wdata = 32'h1; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        chk("awfirst_bvalid", 64'(bus.bvalid), 64'd1);
        chk("awfirst_pulse", 64'(pulse), 64'h0200);
        chk("reg9", 64'(regs[9*32 +: 32]), 64'd1);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;

        rd(32'h40, 32'h0, EXP_RANGE);
        rd(32'h06, 32'h0, RESP_SLVERR);
        wr(32'h06, 32'hFFFFFFFF, 4'hF, RESP_SLVERR, 16'h0000);
        chk("reg1_misaligned", 64'(regs[1*32 +: 32]), 64'd0);
        wr(32'h40, 32'hFFFFFFFF, 4'hF, EXP_RANGE, 16'h0000);

        // Same-edge read and write of reg 0
        bus.awaddr = 32'h0; bus.wdata = 32'h5; bus.wstrb = 4'hF; bus.araddr = 32'h0;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        chk("race_rvalid", 64'(bus.rvalid), 64'd1);
        chk("race_rdata_old", 64'(bus.rdata), 64'd0);
        chk("race_bvalid", 64'(bus.bvalid), 64'd1);
        chk("race_reg0", 64'(regs[31:0]), 64'd5);
        bus.bready = 1'b1; bus.rready = 1'b1;
        tick();
        bus.bready = 1'b0; bus.rready = 1'b0;
        rd(32'h0, 32'h5, RESP_OKAY);

        // Reset while a read response is stalled
        bus.araddr = 32'h10; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        chk("mid_rvalid", 64'(bus.rvalid), 64'd1);
        rstn = 1'b0;
        tick();
        chk("midrst_rvalid", 64'(bus.rvalid), 64'd0);
        chk("midrst_rdata", 64'(bus.rdata), 64'd0);
        chk("midrst_reg4", 64'(regs[4*32 +: 32]), 64'd0);
        chk("midrst_reg0", 64'(regs[31:0]), 64'd0);
        chk("midrst_arready", 64'(bus.arready), 64'd1);
        rstn = 1'b1;
        tick();
        chk("postrst_arready", 64'(bus.arready), 64'd1);
        chk("postrst_bvalid", 64'(bus.bvalid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
